stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, stack entries; a power of two, at least 4.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port STACK_ENB  input  1  request strobe from the instruction-type decoder.
REQ-006 SHALL have port STACK_OP  input  2  operation: 00 push, 01 pop, 10 peek, 11 nop.
REQ-007 SHALL have port DIN  input  WIDTH  push data.
REQ-008 SHALL have port ERR_CLR  input  1  clears sticky error flags (config-dependent).
REQ-009 SHALL have port READY  output  1  high when the unit accepts a request.
REQ-010 SHALL have port DOUT  output  WIDTH  pop/peek result.
REQ-011 SHALL have port DOUT_VALID  output  1  one-cycle pulse qualifying DOUT.
REQ-012 SHALL have ports FULL, EMPTY  output  1 each  stack occupancy status.
REQ-013 SHALL have ports OVF, UNF  output  1 each  overflow and underflow error flags.

Function
REQ-014 SHALL accept a request only in a cycle where STACK_ENB=1 and READY=1; STACK_ENB while READY=0 is ignored, not queued.
REQ-015 SHALL implement FSM states IDLE, READ, RESP; READY=1 only in IDLE.
REQ-016 Push accepted, not full: SHALL write DIN at SP, increment SP, stay in IDLE; READY remains 1.
REQ-017 Pop or peek accepted, not empty: SHALL go IDLE->READ->RESP->IDLE; DOUT_VALID=1 in RESP, which is the 2nd cycle after acceptance.
REQ-018 Pop SHALL decrement SP on acceptance; peek SHALL leave SP unchanged; both return the entry at SP-1 as it was before acceptance.
REQ-019 DOUT SHALL hold its last value until the next RESP.
REQ-020 SP SHALL range 0..DEPTH (log2(DEPTH)+1 bits), never wrap; EMPTY=(SP==0), FULL=(SP==DEPTH), both combinational from SP.
REQ-021 Push when FULL: no write, SP unchanged, OVF raised, stay in IDLE.
REQ-022 Pop or peek when EMPTY: SP unchanged, no DOUT_VALID, UNF raised, stay in IDLE.
REQ-023 Nop, or STACK_ENB=0: no state change.
REQ-024 ERR_CLR asserted in the same cycle as a new error: the error SHALL win and the flag ends set.

Reset
REQ-025 RST_N low SHALL asynchronously force state IDLE, SP=0, DOUT=0, DOUT_VALID=0, OVF=0, UNF=0; hence READY=1, EMPTY=1, FULL=0.
REQ-026 Reset during READ or RESP SHALL abort the operation with no DOUT_VALID pulse; storage contents need not be cleared.

Configuration
REQ-027 With STACK_ERR_STICKY_EN defined, OVF/UNF SHALL stay set until ERR_CLR=1 or reset.
REQ-028 Without STACK_ERR_STICKY_EN, OVF/UNF SHALL each be a one-cycle pulse in the cycle after the offending request, and ERR_CLR is ignored.

Structure
REQ-029 Package stack_pkg SHALL hold the STACK_OP encodings, FSM state encoding, and WIDTH/DEPTH defaults.
REQ-030 Storage SHALL be sub-module stack_mem: register array with one write port, one registered read port, and no reset on data.

Verification
REQ-031 Reset, then push 0x1111, 0x2222, then pop -> DOUT=0x2222 with DOUT_VALID two cycles after acceptance, READY low for 2 cycles, SP=1.
REQ-032 Pop on empty after reset -> UNF=1, no DOUT_VALID, SP=0; with STACK_ERR_STICKY_EN, UNF stays set until ERR_CLR.
REQ-033 Push 16 values 0x0000..0x000F -> FULL=1; 17th push 0xBEEF -> OVF=1, then pop returns 0x000F.
REQ-034 Peek after push 0xA5A5 -> DOUT=0xA5A5, SP unchanged; a following pop also returns 0xA5A5 and sets EMPTY.
REQ-035 STACK_ENB pulsed with push 0x7777 during READ of a pop -> request ignored, SP unchanged afterward.
REQ-036 RST_N low during READ -> no DOUT_VALID, SP=0, READY=1 immediately.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the hardware stack unit: operation codes, FSM states
// and default geometry.
package stack_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_PEEK = 2'b10,
      OP_NOP  = 2'b11
   } stack_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: register array with one write port and one registered read
// port; data is never reset.
module stack_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/stack_unit.sv
// Hardware stack with push/pop/peek, two-cycle read response and error flags.
// Define STACK_ERR_STICKY_EN to make OVF/UNF sticky until ERR_CLR or reset.
module stack_unit
   import stack_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             STACK_ENB,
   input  logic [1:0]       STACK_OP,
   input  logic [WIDTH-1:0] DIN,
   input  logic             ERR_CLR,
   output logic             READY,
   output logic [WIDTH-1:0] DOUT,
   output logic             DOUT_VALID,
   output logic             FULL,
   output logic             EMPTY,
   output logic             OVF,
   output logic             UNF
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q, state_d;
   stack_op_e        op;
   logic [AW:0]      sp_q;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] rd_data_p1;
   logic             do_push, do_pop, do_read;
   logic             ovf_set, unf_set;

   assign op    = stack_op_e'(STACK_OP);
   assign EMPTY = (sp_q == '0);
   assign FULL  = (sp_q == (AW+1)'(DEPTH));
   assign raddr = sp_q[AW-1:0] - 1'b1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      READY      = 1'b0;
      DOUT_VALID = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      do_read    = 1'b0;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            READY = 1'b1;
            if (STACK_ENB) begin
               case (op)
                  OP_PUSH: begin
                     if (FULL) ovf_set = 1'b1;
                     else      do_push = 1'b1;
                  end
                  OP_POP, OP_PEEK: begin
                     if (EMPTY) begin
                        unf_set = 1'b1;
                     end else begin
                        do_read = 1'b1;
                        do_pop  = (op == OP_POP);
                        state_d = ST_READ;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_READ: state_d = ST_RESP;
         ST_RESP: begin
            DOUT_VALID = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage p0: stack pointer moves on acceptance; the read is issued with the old top.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sp_q <= '0;
      end else if (do_push) begin
         sp_q <= sp_q + 1'b1;
      end else if (do_pop) begin
         sp_q <= sp_q - 1'b1;
      end
   end

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (CLK),
      .we    (do_push),
      .waddr (sp_q[AW-1:0]),
      .wdata (DIN),
      .re    (do_read),
      .raddr (raddr),
      .rdata (rd_data_p1)
   );

   // Stage p1 -> p2: capture read data into DOUT as the FSM enters RESP.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DOUT <= '0;
      end else if (state_q == ST_READ) begin
         DOUT <= rd_data_p1;
      end
   end

`ifdef STACK_ERR_STICKY_EN
   // A new error in the same cycle as ERR_CLR takes priority.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OVF <= 1'b0;
         UNF <= 1'b0;
      end else begin
         if (ovf_set)      OVF <= 1'b1;
         else if (ERR_CLR) OVF <= 1'b0;
         if (unf_set)      UNF <= 1'b1;
         else if (ERR_CLR) UNF <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = ERR_CLR;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OVF <= 1'b0;
         UNF <= 1'b0;
      end else begin
         OVF <= ovf_set;
         UNF <= unf_set;
      end
   end
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus randomized
// traffic against a queue-based reference stack.
module tb_stack_unit;

   localparam int W = 16;
   localparam int D = 16;
   localparam logic [1:0] PUSH = 2'b00;
   localparam logic [1:0] POP  = 2'b01;
   localparam logic [1:0] PEEK = 2'b10;
   localparam logic [1:0] NOP  = 2'b11;
`ifdef STACK_ERR_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          STACK_ENB;
   logic [1:0]    STACK_OP;
   logic [W-1:0]  DIN;
   logic          ERR_CLR;
   logic          READY;
   logic [W-1:0]  DOUT;
   logic          DOUT_VALID;
   logic          FULL;
   logic          EMPTY;
   logic          OVF;
   logic          UNF;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [W-1:0] model [$];

   stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .STACK_ENB  (STACK_ENB),
      .STACK_OP   (STACK_OP),
      .DIN        (DIN),
      .ERR_CLR    (ERR_CLR),
      .READY      (READY),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .FULL       (FULL),
      .EMPTY      (EMPTY),
      .OVF        (OVF),
      .UNF        (UNF)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog expired: bench did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_req(input logic [1:0] op, input logic [W-1:0] d, input logic clr);
      STACK_ENB = 1'b1;
      STACK_OP  = op;
      DIN       = d;
      ERR_CLR   = clr;
      step();
      STACK_ENB = 1'b0;
      STACK_OP  = NOP;
      ERR_CLR   = 1'b0;
   endtask

   // Issues a pop/peek and watches a bounded window for the response.
   task automatic do_read(input logic [1:0] op, input logic clr, output int lat,
                          output logic [W-1:0] data, output logic rdy1,
                          output logic rdy2, output logic err1);
      lat  = 0;
      data = '0;
      rdy2 = 1'b1;
      do_req(op, '0, clr);
      rdy1 = READY;
      err1 = UNF;
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) rdy2 = READY;
         if (DOUT_VALID === 1'b1) begin
            lat  = c;
            data = DOUT;
            step();
            break;
         end
         step();
      end
   endtask

   task automatic apply_reset();
      STACK_ENB = 1'b0;
      STACK_OP  = NOP;
      DIN       = '0;
      ERR_CLR   = 1'b0;
      RST_N     = 1'b0;
      step();
      step();
      @(negedge CLK);
      RST_N = 1'b1;
      step();
      model.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      RST_N = 1'b0;
      #2;
      total_cnt++;
      if ({READY, EMPTY, FULL, DOUT_VALID, OVF, UNF} !== 6'b110000)
         $display("FAIL reset_flags got=%b exp=110000", {READY, EMPTY, FULL, DOUT_VALID, OVF, UNF});
      else pass_cnt++;
      total_cnt++;
      if (DOUT !== '0) $display("FAIL reset_dout got=%h exp=0000", DOUT);
      else pass_cnt++;
      @(negedge CLK);
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_push_pop();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      apply_reset();
      do_req(PUSH, 16'h1111, 1'b0);
      do_req(PUSH, 16'h2222, 1'b0);
      total_cnt++;
      if ({READY, EMPTY} !== 2'b10) $display("FAIL push_ready got=%b exp=10", {READY, EMPTY});
      else pass_cnt++;
      do_read(POP, 1'b0, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 2 || data !== 16'h2222)
         $display("FAIL pop_2222 got lat=%0d data=%h exp lat=2 data=2222", lat, data);
      else pass_cnt++;
      total_cnt++;
      if ({r1, r2} !== 2'b00) $display("FAIL pop_busy got ready=%b exp=00", {r1, r2});
      else pass_cnt++;
      total_cnt++;
      if ({READY, EMPTY, DOUT_VALID} !== 3'b100 || DOUT !== 16'h2222)
         $display("FAIL pop_after got flags=%b dout=%h exp flags=100 dout=2222",
                  {READY, EMPTY, DOUT_VALID}, DOUT);
      else pass_cnt++;
      do_read(POP, 1'b0, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 2 || data !== 16'h1111 || EMPTY !== 1'b1)
         $display("FAIL pop_1111 got lat=%0d data=%h empty=%b exp 2/1111/1", lat, data, EMPTY);
      else pass_cnt++;
   endtask

   task automatic test_underflow();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      apply_reset();
      do_read(POP, 1'b0, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 0 || e1 !== 1'b1 || r1 !== 1'b1 || EMPTY !== 1'b1)
         $display("FAIL unf_pop got lat=%0d unf=%b ready=%b empty=%b exp 0/1/1/1", lat, e1, r1, EMPTY);
      else pass_cnt++;
      total_cnt++;
      if (UNF !== STICKY || DOUT !== '0)
         $display("FAIL unf_hold got unf=%b dout=%h exp unf=%b dout=0000", UNF, DOUT, STICKY);
      else pass_cnt++;
      ERR_CLR = 1'b1;
      step();
      ERR_CLR = 1'b0;
      total_cnt++;
      if (UNF !== 1'b0) $display("FAIL unf_clr got=%b exp=0", UNF);
      else pass_cnt++;
      do_read(PEEK, 1'b1, lat, data, r1, r2, e1);
      total_cnt++;
      if (e1 !== 1'b1 || lat !== 0)
         $display("FAIL unf_vs_clr got unf=%b lat=%0d exp unf=1 lat=0", e1, lat);
      else pass_cnt++;
   endtask

   task automatic test_full_overflow();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      apply_reset();
      for (int i = 0; i < D; i++) do_req(PUSH, W'(i), 1'b0);
      total_cnt++;
      if ({FULL, EMPTY} !== 2'b10) $display("FAIL full_flag got=%b exp=10", {FULL, EMPTY});
      else pass_cnt++;
      do_req(PUSH, 16'hBEEF, 1'b0);
      total_cnt++;
      if ({OVF, READY, FULL} !== 3'b111) $display("FAIL ovf_set got=%b exp=111", {OVF, READY, FULL});
      else pass_cnt++;
      step();
      total_cnt++;
      if (OVF !== STICKY) $display("FAIL ovf_next got=%b exp=%b", OVF, STICKY);
      else pass_cnt++;
      do_read(POP, 1'b1, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 2 || data !== 16'h000F || FULL !== 1'b0 || OVF !== 1'b0)
         $display("FAIL pop_after_full got lat=%0d data=%h full=%b ovf=%b exp 2/000f/0/0",
                  lat, data, FULL, OVF);
      else pass_cnt++;
   endtask

   task automatic test_peek();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      apply_reset();
      do_req(PUSH, 16'hA5A5, 1'b0);
      do_read(PEEK, 1'b0, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 2 || data !== 16'hA5A5 || EMPTY !== 1'b0)
         $display("FAIL peek got lat=%0d data=%h empty=%b exp 2/a5a5/0", lat, data, EMPTY);
      else pass_cnt++;
      do_read(POP, 1'b0, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 2 || data !== 16'hA5A5 || EMPTY !== 1'b1)
         $display("FAIL peek_pop got lat=%0d data=%h empty=%b exp 2/a5a5/1", lat, data, EMPTY);
      else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      apply_reset();
      do_req(PUSH, 16'h1234, 1'b0);
      STACK_ENB = 1'b1;
      STACK_OP  = POP;
      step();
      total_cnt++;
      if (READY !== 1'b0) $display("FAIL busy_ready got=%b exp=0", READY);
      else pass_cnt++;
      STACK_OP = PUSH;
      DIN      = 16'h7777;
      step();
      STACK_ENB = 1'b0;
      STACK_OP  = NOP;
      total_cnt++;
      if (DOUT_VALID !== 1'b1 || DOUT !== 16'h1234)
         $display("FAIL busy_resp got vld=%b dout=%h exp 1/1234", DOUT_VALID, DOUT);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({READY, EMPTY} !== 2'b11) $display("FAIL busy_ignored got=%b exp=11", {READY, EMPTY});
      else pass_cnt++;
      do_read(POP, 1'b0, lat, data, r1, r2, e1);
      total_cnt++;
      if (lat !== 0 || e1 !== 1'b1)
         $display("FAIL busy_nodata got lat=%0d unf=%b exp 0/1", lat, e1);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_read();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      logic vld_seen;
      apply_reset();
      do_req(PUSH, 16'h5555, 1'b0);
      do_read(PEEK, 1'b0, lat, data, r1, r2, e1);
      STACK_ENB = 1'b1;
      STACK_OP  = POP;
      step();
      STACK_ENB = 1'b0;
      STACK_OP  = NOP;
      #1;
      RST_N = 1'b0;
      #1;
      total_cnt++;
      if ({READY, EMPTY, FULL, DOUT_VALID, OVF, UNF} !== 6'b110000 || DOUT !== '0)
         $display("FAIL rst_read got flags=%b dout=%h exp flags=110000 dout=0000",
                  {READY, EMPTY, FULL, DOUT_VALID, OVF, UNF}, DOUT);
      else pass_cnt++;
      vld_seen = 1'b0;
      step();
      vld_seen |= DOUT_VALID;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vld_seen |= DOUT_VALID;
      end
      total_cnt++;
      if (vld_seen !== 1'b0 || EMPTY !== 1'b1 || READY !== 1'b1)
         $display("FAIL rst_abort got vld=%b empty=%b ready=%b exp 0/1/1", vld_seen, EMPTY, READY);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int lat; logic [W-1:0] data; logic r1, r2, e1;
      logic [W-1:0] d, exp_d;
      logic [1:0] op;
      int r;
      logic exp_ovf;
      apply_reset();
      for (int n = 0; n < 300; n++) begin
         d = W'($urandom);
         r = $urandom_range(0, 9);
         if (((n / 60) % 2) == 0) op = (r < 6) ? PUSH : (r < 8) ? POP : (r < 9) ? PEEK : NOP;
         else                     op = (r < 2) ? PUSH : (r < 7) ? POP : (r < 9) ? PEEK : NOP;
         if ($urandom_range(0, 4) == 0) begin
            STACK_ENB = 1'b0;
            STACK_OP  = op;
            DIN       = d;
            step();
            STACK_OP  = NOP;
            total_cnt++;
            if (DOUT_VALID !== 1'b0 || READY !== 1'b1)
               $display("FAIL rnd_idle n=%0d got vld=%b ready=%b exp 0/1", n, DOUT_VALID, READY);
            else pass_cnt++;
         end else if (op == PUSH) begin
            exp_ovf = (model.size() == D);
            do_req(PUSH, d, 1'b1);
            total_cnt++;
            if (OVF !== exp_ovf) $display("FAIL rnd_push_ovf n=%0d got=%b exp=%b", n, OVF, exp_ovf);
            else pass_cnt++;
            if (!exp_ovf) model.push_back(d);
         end else if (op == NOP) begin
            do_req(NOP, d, 1'b1);
            total_cnt++;
            if ({OVF, UNF, READY, DOUT_VALID} !== 4'b0010)
               $display("FAIL rnd_nop n=%0d got=%b exp=0010", n, {OVF, UNF, READY, DOUT_VALID});
            else pass_cnt++;
         end else if (model.size() == 0) begin
            do_read(op, 1'b1, lat, data, r1, r2, e1);
            total_cnt++;
            if (lat !== 0 || e1 !== 1'b1)
               $display("FAIL rnd_unf n=%0d got lat=%0d unf=%b exp 0/1", n, lat, e1);
            else pass_cnt++;
         end else begin
            exp_d = model[$];
            if (op == POP) void'(model.pop_back());
            do_read(op, 1'b1, lat, data, r1, r2, e1);
            total_cnt++;
            if (lat !== 2 || data !== exp_d || e1 !== 1'b0)
               $display("FAIL rnd_read n=%0d got lat=%0d data=%h unf=%b exp 2/%h/0", n, lat, data, e1, exp_d);
            else pass_cnt++;
         end
         total_cnt++;
         if ({FULL, EMPTY} !== {model.size() == D, model.size() == 0})
            $display("FAIL rnd_occ n=%0d got full/empty=%b exp size=%0d", n, {FULL, EMPTY}, model.size());
         else pass_cnt++;
      end
   endtask

   initial begin
      RST_N     = 1'b0;
      STACK_ENB = 1'b0;
      STACK_OP  = NOP;
      DIN       = '0;
      ERR_CLR   = 1'b0;
      test_reset();
      test_push_pop();
      test_underflow();
      test_full_overflow();
      test_peek();
      test_busy_ignore();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
